// File: rtl/zero_cond_unit.sv
// zero_cond_unit: registered 8-way zero/sign condition evaluator behind a one-deep valid/ready stage.
// Define COND_TAKEN_CNT_EN to add the saturating taken_cnt counter port.
module zero_cond_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eqz,
    output logic             eq1,
    output logic             neg,
    output logic             cond
`ifdef COND_TAKEN_CNT_EN
    ,
    output logic [CNT_W-1:0] taken_cnt
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;
    logic acc, z, o, msb, c;
    logic [7:0] conds;
    assign out_valid = state == FULL;
    assign in_ready = !out_valid || out_ready;
    assign acc = in_valid && in_ready;
    assign z = s == '0;
    assign o = s == WIDTH'(1);
    assign msb = s[WIDTH-1];
    // bit index matches the mode encoding: ALWAYS, EQ1, LEZ, GTZ, GEZ, LTZ, NEZ, EQZ
    assign conds = {1'b1, o, msb || z, !msb && !z, !msb, msb, !z, z};
    assign c = conds[mode];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            eqz <= 1'b0;
            eq1 <= 1'b0;
            neg <= 1'b0;
            cond <= 1'b0;
        end else if (acc) begin
            state <= FULL;
            eqz <= z;
            eq1 <= o;
            neg <= msb;
            cond <= c;
        end else if (out_valid && out_ready) begin
            state <= EMPTY;
        end
    end
`ifdef COND_TAKEN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) taken_cnt <= '0;
        else if (acc && c && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
    end
`endif
endmodule

// File: doc/zero_cond_unit.md
Name: zero_cond_unit

Overview:
- Parametrised, registered successor to the team's 32-bit zero-detect comparator.
- Evaluates one of eight branch/compare conditions on a WIDTH-bit operand and returns per-operand flags through a one-deep valid/ready output register.
- Sits between the ALU result bus and branch/writeback control.
- Supports back-pressure, so downstream stalls never drop a result.

Parameters:
- WIDTH, 32, operand width in bits (minimum 2).
- CNT_W, 16, width of the optional taken counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand and mode presented.
- in_ready  output  1  unit can accept this cycle.
- s  input  WIDTH  operand, two's complement.
- mode  input  3  condition select, see Behaviour.
- out_valid  output  1  registered result available.
- out_ready  input  1  consumer accepts result.
- eqz  output  1  registered s == 0.
- eq1  output  1  registered s == 1.
- neg  output  1  registered s[WIDTH-1].
- cond  output  1  registered selected condition.
- taken_cnt  output  CNT_W  present only with COND_TAKEN_CNT_EN.

Behaviour:
- Reset, synchronous to clk while rst=1:
  - out_valid=0; eqz=0, eq1=0, neg=0, cond=0.
  - taken_cnt=0 if the feature is present.
  - in_ready reads 1 in the first cycle after reset deasserts.
- Handshakes:
  - in_ready = !out_valid || out_ready (combinational).
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Latency: exactly 1 cycle. Results for the operand accepted in cycle N appear with out_valid=1 in cycle N+1.
- Output register update at each clock edge when rst=0:
  - Accept: load eqz, eq1, neg, cond from s/mode; out_valid <= 1.
  - Consume without accept: out_valid <= 0; flag registers hold their last value.
  - Neither: all hold. A stalled result (out_valid && !out_ready) stays stable until consumed.
  - Simultaneous consume and accept: new result replaces the old one; out_valid stays 1, with no bubble. Full throughput is one result per cycle.
- Mode encoding, evaluated on the accepted s:
  - 0 EQZ: s==0.
  - 1 NEZ: s!=0.
  - 2 LTZ: s[WIDTH-1]=1.
  - 3 GEZ: s[WIDTH-1]=0.
  - 4 GTZ: !msb && s!=0.
  - 5 LEZ: msb || s==0.
  - 6 EQ1: s==1.
  - 7 ALWAYS: 1.
- Boundaries:
  - Most-negative value (only msb set): LTZ=1, eqz=0.
  - All-ones: neg=1, eq1=0.
  - s=1: eq1=1, GTZ=1.
  - mode and s are ignored when not accepted; X on them while in_valid=0 must not propagate.
- State: the output register acts as a two-state machine, EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume without accept.
  - FULL -> FULL on accept+consume, or on stall.
- Reset mid-operation: a pending, unconsumed result is discarded; no output is produced for it.

Optional Feature:
- Macro: COND_TAKEN_CNT_EN.
- Defined:
  - taken_cnt port exists.
  - Increments by 1 on each accepted input whose evaluated condition is 1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
  - Counts at accept time, independent of out_ready.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 2 cycles with out_ready=0 -> out_valid=0, cond=0, in_ready=1 after release; taken_cnt=0.
- Mode sweep, WIDTH=32, out_ready=1: s in {0x00000000, 0x00000001, 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF} × modes 0..7 -> each result 1 cycle later.
  - Example: s=0x80000000, mode=2 -> cond=1, neg=1, eqz=0.
  - Example: s=0x00000001, mode=6 -> cond=1, eq1=1.
- Back-pressure: accept s=0, mode 0; hold out_ready=0 for 3 cycles while in_valid=1 with s=5 -> in_ready=0, eqz/cond stay 1, out_valid=1. Then raise out_ready -> s=5 accepted the same cycle; next cycle eqz=0, cond=0.
- Streaming: 8 back-to-back operands with out_ready=1 -> in_ready held 1 throughout, 8 results in order on consecutive cycles, no bubbles.
- Reset mid-stall: result pending with out_ready=0, assert rst for 1 cycle -> out_valid=0 next cycle; the pending result is never output.
- COND_TAKEN_CNT_EN with CNT_W=2: 5 accepts with mode 7 -> taken_cnt sequence 1, 2, 3, 3, 3; 2 accepts with mode 0 and s=4 -> count unchanged.
